// File: rtl/if_pc_gen_if.sv
// Bus bundle between the instruction-fetch PC generator and the rest of the
// pipeline: stall vector and branch redirect in, the IF->ID bus and the
// instruction SRAM request out, plus fetch statistics and error flag.
interface if_pc_gen_if #(
   parameter int STALL_WD    = 6,
   parameter int BR_WD       = 33,
   parameter int IF_TO_ID_WD = 33
);
   logic [STALL_WD-1:0]    stall;
   logic [BR_WD-1:0]       br_bus;
   logic [IF_TO_ID_WD-1:0] if_to_id_bus;
   logic                   inst_sram_en;
   logic [3:0]             inst_sram_wen;
   logic [31:0]            inst_sram_addr;
   logic [31:0]            inst_sram_wdata;
   logic [31:0]            fetch_cnt;
   logic                   addr_err;

   // Fetch stage side.
   modport master (
      input  stall, br_bus,
      output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
             inst_sram_wdata, fetch_cnt, addr_err
   );

   // Pipeline / memory side.
   modport slave (
      output stall, br_bus,
      input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_addr,
             inst_sram_wdata, fetch_cnt, addr_err
   );
endinterface

// File: rtl/if_pc_gen.sv
// Instruction-fetch PC generator for the five-stage MIPS pipeline.
// Owns the PC, drives synchronous reads of the instruction SRAM and forwards
// {ce, pc} to decode. A branch redirect that arrives while fetch is stalled is
// held and applied on the first unstalled cycle; a live redirect on that
// cycle takes precedence over the held one.
// Optional feature macro: IF_ADDR_ERR_EN -- flags misaligned fetches on
// addr_err and suppresses both the SRAM read and the ce bit towards decode.
module if_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
   input  logic       clk,
   input  logic       rst,
   if_pc_gen_if.master bus
);
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   logic [31:0] pc_reg;
   logic        ce_reg;
   logic        pend_v;
   logic [31:0] pend_addr;
   logic [31:0] fetch_cnt_reg;
   logic [31:0] next_pc;
   logic        advance;
   logic        br_e;
   logic [31:0] br_addr;
   logic        err_mask;
   logic        unused_stall;

   assign br_e    = bus.br_bus[32];
   assign br_addr = bus.br_bus[31:0];
   assign advance = (bus.stall[0] == NO_STOP);

   // Only bit 0 of the stall vector concerns the PC/IF stage.
   assign unused_stall = ^(bus.stall >> 1);

   // Next-PC priority: live redirect, then held redirect, then sequential.
   // NOTE: always_comb assigns a default first so no path leaves next_pc
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_pc = pc_reg + 32'd4;
      if (pend_v) next_pc = pend_addr;
      if (br_e)   next_pc = br_addr;
   end

   // PC, fetch enable and held-redirect registers; reset dominates everything.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg    <= RESET_PC;
         ce_reg    <= 1'b0;
         pend_v    <= 1'b0;
         pend_addr <= 32'h0;
      end else if (advance) begin
         pc_reg <= next_pc;
         ce_reg <= 1'b1;
         pend_v <= 1'b0;
      end else if (bus.stall[0] == STOP && br_e) begin
         pend_v    <= 1'b1;
         pend_addr <= br_addr;
      end
   end

   // Count fetches accepted by the pipeline; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst)                  fetch_cnt_reg <= 32'h0;
      else if (ce_reg && advance) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
   end

`ifdef IF_ADDR_ERR_EN
   logic addr_err_reg;

   // Misalignment flag tracks pc_reg: it is loaded with the alignment of the
   // address pc_reg is about to take, so it equals (pc misaligned && ce).
   always_ff @(posedge clk) begin
      if (rst)          addr_err_reg <= 1'b0;
      else if (advance) addr_err_reg <= (next_pc[1:0] != 2'b00);
   end

   assign err_mask = addr_err_reg;
`else
   assign err_mask = 1'b0;
`endif

   assign bus.addr_err        = err_mask;
   assign bus.inst_sram_en    = ce_reg & ~err_mask;
   assign bus.inst_sram_wen   = 4'b0000;
   assign bus.inst_sram_addr  = pc_reg;
   assign bus.inst_sram_wdata = 32'h0;
   assign bus.if_to_id_bus    = {ce_reg & ~err_mask, pc_reg};
   assign bus.fetch_cnt       = fetch_cnt_reg;
endmodule
